// File: rtl/mult_seq_pkg.sv
// Shared types and sizing helpers for the parametrised sequential multiplier.
package mult_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  // Number of chunk-by-chunk partial products needed for one full product.
  function automatic int steps(input int aw, input int bw, input int ac, input int bc);
    return (aw / ac) * (bw / bc);
  endfunction

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult_seq_param_if.sv
// start/busy/done handshake plus operand/result bus for mult_seq_param.
// MULT_SIGNED_EN adds the is_signed request bit.
interface mult_seq_param_if #(
  parameter int A_WIDTH = 32,
  parameter int B_WIDTH = 32
);
  logic                       start;
  logic [A_WIDTH-1:0]         a;
  logic [B_WIDTH-1:0]         b;
`ifdef MULT_SIGNED_EN
  logic                       is_signed;
`endif
  logic                       busy;
  logic                       done;
  logic [A_WIDTH+B_WIDTH-1:0] product;

`ifdef MULT_SIGNED_EN
  modport master (output start, a, b, is_signed, input busy, done, product);
  modport slave  (input start, a, b, is_signed, output busy, done, product);
`else
  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
`endif
endinterface

// File: rtl/mult_seq_pp.sv
// One partial product: selects a-slice i and b-slice j, multiplies them and
// places the result at its weight inside the full-width product.
module mult_seq_pp #(
  parameter int A_WIDTH = 32,
  parameter int B_WIDTH = 32,
  parameter int A_CHUNK = 8,
  parameter int B_CHUNK = 16,
  parameter int IW      = 2,
  parameter int JW      = 1
) (
  input  logic [A_WIDTH-1:0]         a,
  input  logic [B_WIDTH-1:0]         b,
  input  logic [IW-1:0]              i,
  input  logic [JW-1:0]              j,
  output logic [A_WIDTH+B_WIDTH-1:0] pp
);
  localparam int PW = A_WIDTH + B_WIDTH;
  localparam int CW = A_CHUNK + B_CHUNK;

  logic [A_CHUNK-1:0] a_sl;
  logic [B_CHUNK-1:0] b_sl;
  logic [CW-1:0]      prod;

  assign a_sl = a[int'(i)*A_CHUNK +: A_CHUNK];
  assign b_sl = b[int'(j)*B_CHUNK +: B_CHUNK];
  assign prod = {{B_CHUNK{1'b0}}, a_sl} * {{A_CHUNK{1'b0}}, b_sl};
  assign pp   = PW'(prod) << (int'(i)*A_CHUNK + int'(j)*B_CHUNK);
endmodule

// File: rtl/mult_seq_param.sv
// Sequential multiplier: one A_CHUNK x B_CHUNK partial product per cycle,
// accumulated into product. Optional signed mode under MULT_SIGNED_EN.
module mult_seq_param
  import mult_seq_pkg::*;
#(
  parameter int A_WIDTH = 32,
  parameter int B_WIDTH = 32,
  parameter int A_CHUNK = 8,
  parameter int B_CHUNK = 16
) (
  input  logic             clk,
  input  logic             reset,
  mult_seq_param_if.slave  bus
);
  localparam int NA = A_WIDTH / A_CHUNK;
  localparam int NB = B_WIDTH / B_CHUNK;
  localparam int N  = steps(A_WIDTH, B_WIDTH, A_CHUNK, B_CHUNK);
  localparam int CW = cnt_w(N);
  localparam int IW = cnt_w(NA);
  localparam int JW = cnt_w(NB);
  localparam int PW = A_WIDTH + B_WIDTH;

  generate
    if ((A_WIDTH % A_CHUNK) != 0 || (B_WIDTH % B_CHUNK) != 0) begin : g_bad_param
      $error("mult_seq_param: widths %0d/%0d not multiples of chunks %0d/%0d",
             A_WIDTH, B_WIDTH, A_CHUNK, B_CHUNK);
    end
  endgenerate

  state_t             state, state_n;
  logic [CW-1:0]      cnt;
  logic [A_WIDTH-1:0] a_lat;
  logic [B_WIDTH-1:0] b_lat;
  logic [PW-1:0]      product;
  logic [PW-1:0]      pp;
  logic               busy, done;
  logic               accept, last;
  logic [IW-1:0]      si;
  logic [JW-1:0]      sj;
`ifdef MULT_SIGNED_EN
  logic               neg;
  logic               a_neg, b_neg;

  assign a_neg = bus.is_signed & bus.a[A_WIDTH-1];
  assign b_neg = bus.is_signed & bus.b[B_WIDTH-1];
`endif

  // Step k walks a-slices fastest: i = k % NA, j = k / NA.
  assign si   = IW'(int'(cnt) % NA);
  assign sj   = JW'(int'(cnt) / NA);
  assign last = (int'(cnt) == N - 1);

  mult_seq_pp #(
    .A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH),
    .A_CHUNK(A_CHUNK), .B_CHUNK(B_CHUNK),
    .IW(IW), .JW(JW)
  ) u_pp (
    .a(a_lat), .b(b_lat), .i(si), .j(sj), .pp(pp)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        accept  = 1'b1;
        state_n = RUN;
      end
`ifdef MULT_SIGNED_EN
      RUN:  if (last) state_n = FIX;
      FIX:  state_n = IDLE;
`else
      RUN:  if (last) state_n = IDLE;
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      a_lat   <= '0;
      b_lat   <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef MULT_SIGNED_EN
      neg     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
`ifdef MULT_SIGNED_EN
        // Negating the most negative value yields its magnitude as unsigned.
        a_lat <= a_neg ? -bus.a : bus.a;
        b_lat <= b_neg ? -bus.b : bus.b;
        neg   <= a_neg ^ b_neg;
`else
        a_lat <= bus.a;
        b_lat <= bus.b;
`endif
        product <= '0;
        cnt     <= '0;
        busy    <= 1'b1;
      end else if (state == RUN) begin
        product <= product + pp;
        cnt     <= cnt + CW'(1);
`ifndef MULT_SIGNED_EN
        if (last) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
`endif
      end
`ifdef MULT_SIGNED_EN
      else if (state == FIX) begin
        product <= neg ? -product : product;
        busy    <= 1'b0;
        done    <= 1'b1;
      end
`endif
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.product = product;
endmodule

// File: tb/tb_mult_seq_param.sv
// Bench for mult_seq_param: default 32x32 instance plus a 16x24 (4x8 chunk) instance,
// checked against plain-arithmetic products.
module tb_mult_seq_param;
  import mult_seq_pkg::*;

`ifdef MULT_SIGNED_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int N1 = 8;
  localparam int N2 = 12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_seq_param_if #(.A_WIDTH(32), .B_WIDTH(32)) bus ();
  mult_seq_param_if #(.A_WIDTH(16), .B_WIDTH(24)) bus2 ();

  mult_seq_param u_dut (.clk(clk), .reset(reset), .bus(bus));
  mult_seq_param #(.A_WIDTH(16), .B_WIDTH(24), .A_CHUNK(4), .B_CHUNK(8))
    u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          sg;
    logic [63:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit sg);
    longint sa, sb;
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_sg(input bit sg);
`ifdef MULT_SIGNED_EN
    bus.is_signed = sg;
`else
    if (sg) $display("note: signed request ignored in unsigned build");
`endif
  endtask

  // One operation on the 32x32 instance; latency = edges after the accepting edge.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input bit sg,
                        output logic [63:0] p, output int lat, output int bcnt, output logic dn2);
    @(negedge clk);
    bus.a = ia; bus.b = ib; set_sg(sg); bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    lat = -1; bcnt = 0;
    for (int c = 1; c <= 100; c++) begin
      if (bus.done) begin lat = c - 1; break; end
      if (bus.busy) bcnt++;
      @(negedge clk);
    end
    p = bus.product;
    @(negedge clk);
    dn2 = bus.done;
  endtask

  initial begin
    logic [63:0] p, p1;
    int lat, bcnt, tmo;
    logic dn2;
    logic [31:0] ra, rb;
    bit rs;

    reset = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    bus2.start = 1'b0; bus2.a = '0; bus2.b = '0;
    set_sg(1'b0);
`ifdef MULT_SIGNED_EN
    bus2.is_signed = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_product", bus.product, 64'd0);
    chk("rst2_product", 64'(bus2.product), 64'd0);
    reset = 1'b0;

    tbl.push_back('{32'd207363151, 32'd206950149, 1'b0, 64'd42913834996559499});
    tbl.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001});
    tbl.push_back('{32'h00000000, 32'h12345678, 1'b0, 64'd0});
    tbl.push_back('{32'h00000001, 32'h80000000, 1'b0, 64'h0000000080000000});
`ifdef MULT_SIGNED_EN
    tbl.push_back('{32'hFFFFFFFD, 32'd5, 1'b1, 64'hFFFFFFFFFFFFFFF1});
    tbl.push_back('{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000});
    tbl.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'd1});
`endif
    for (int k = 0; k < 10; k++) begin
      ra = $urandom; rb = $urandom;
`ifdef MULT_SIGNED_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      tbl.push_back('{ra, rb, rs, ref_mul(ra, rb, rs)});
    end

    foreach (tbl[k]) begin
      run_op(tbl[k].a, tbl[k].b, tbl[k].sg, p, lat, bcnt, dn2);
      chk($sformatf("vec%0d_product", k), p, tbl[k].exp);
      chk($sformatf("vec%0d_latency", k), 64'(lat), 64'(N1 + EXTRA));
      chk($sformatf("vec%0d_busy_cycles", k), 64'(bcnt), 64'(N1 + EXTRA));
      chk($sformatf("vec%0d_done_pulse", k), 64'(dn2), 64'd0);
    end

    // start held high, operands changed mid-run: must not disturb the running op.
    @(negedge clk);
    bus.a = 32'd1000; bus.b = 32'd3000; set_sg(1'b0); bus.start = 1'b1;
    @(posedge clk);
    repeat (4) @(negedge clk);
    bus.a = 32'd77; bus.b = 32'd11;
    tmo = 1;
    for (int c = 0; c < 50; c++) begin
      if (bus.done) begin tmo = 0; break; end
      @(negedge clk);
    end
    chk("hold_timeout", 64'(tmo), 64'd0);
    chk("hold_first_product", bus.product, 64'd3000000);
    @(negedge clk);
    chk("hold_restart_busy", 64'(bus.busy), 64'd1);
    bus.start = 1'b0;
    tmo = 1;
    for (int c = 0; c < 50; c++) begin
      if (bus.done) begin tmo = 0; break; end
      @(negedge clk);
    end
    chk("hold_second_product", bus.product, ref_mul(32'd77, 32'd11, 1'b0));

    // Async reset in the middle of an operation.
    @(negedge clk);
    bus.a = 32'hDEADBEEF; bus.b = 32'hCAFEF00D; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_product", bus.product, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(32'd3, 32'd5, 1'b0, p, lat, bcnt, dn2);
    chk("midrst_fresh_product", p, 64'd15);
    chk("midrst_fresh_latency", 64'(lat), 64'(N1 + EXTRA));

    // 16x24 instance with 4x8 chunks.
    for (int k = 0; k < 5; k++) begin
      logic [15:0] a2;
      logic [23:0] b2;
      a2 = (k == 0) ? 16'hFFFF : 16'($urandom);
      b2 = (k == 0) ? 24'hFFFFFF : 24'($urandom);
      @(negedge clk);
      bus2.a = a2; bus2.b = b2; bus2.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus2.start = 1'b0;
      lat = -1;
      for (int c = 1; c <= 100; c++) begin
        if (bus2.done) begin lat = c - 1; break; end
        @(negedge clk);
      end
      chk($sformatf("p2_%0d_product", k), 64'(bus2.product),
          (k == 0) ? 64'h000000FFFEFF0001 : ({48'b0, a2} * {40'b0, b2}));
      chk($sformatf("p2_%0d_latency", k), 64'(lat), 64'(N2 + EXTRA));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
